// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate front end and the parking controller:
// direction FSM encoding and default tuning values.
package parking_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_CAPACITY        = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IN_A  = 3'd1,
    IN_B  = 3'd2,
    IN_C  = 3'd3,
    OUT_A = 3'd4,
    OUT_B = 3'd5,
    OUT_C = 3'd6
  } gate_state_t;

endpackage

// File: rtl/beam_debounce.sv
// One light beam: 2-flop synchroniser followed by a stability counter that only
// lets the debounced level follow after DEBOUNCE_CYCLES consecutive differing cycles.
module beam_debounce
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb
);

  logic       sync_q1;
  logic       sync_q2;
  logic [7:0] stable_cnt;

  // Any cycle where the synchronised level agrees with deb restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1    <= 1'b0;
      sync_q2    <= 1'b0;
      deb        <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      if (sync_q2 == deb) begin
        stable_cnt <= '0;
      end else if (stable_cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
        deb        <= sync_q2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/parking_gate_sensor_frontend.sv
// Gate sensor front end: debounces both beams, classifies complete passages,
// keeps a saturating occupancy count and gates the entrance request when full.
module parking_gate_sensor_frontend
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CAPACITY        = DEFAULT_CAPACITY,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_entrance,
  input  logic             raw_exit,
  output logic             sensor_entrance,
  output logic             sensor_exit,
  output logic             car_in_pulse,
  output logic             car_out_pulse,
  output logic [CNT_W-1:0] occupancy,
  output logic             lot_full,
  output logic             lot_empty
);

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  logic             deb_entrance;
  logic             deb_exit;
  logic [1:0]       beams;
  gate_state_t      state;
  gate_state_t      state_next;
  logic             in_evt;
  logic             out_evt;
  logic [CNT_W-1:0] occ_next;

  beam_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_entrance (
    .clk   (clk),
    .reset (reset),
    .raw   (raw_entrance),
    .deb   (deb_entrance)
  );

  beam_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_exit (
    .clk   (clk),
    .reset (reset),
    .raw   (raw_exit),
    .deb   (deb_exit)
  );

  assign beams = {deb_entrance, deb_exit};

  // A passage only counts once the vehicle has cleared the far beam last.
  always_comb begin
    state_next = state;
    in_evt     = 1'b0;
    out_evt    = 1'b0;
    case (state)
      IDLE: begin
        if (beams == 2'b10)      state_next = IN_A;
        else if (beams == 2'b01) state_next = OUT_A;
      end
      IN_A: begin
        case (beams)
          2'b11:   state_next = IN_B;
          2'b01:   state_next = IN_C;
          2'b00:   state_next = IDLE;
          default: state_next = IN_A;
        endcase
      end
      IN_B: begin
        case (beams)
          2'b01:   state_next = IN_C;
          2'b10:   state_next = IN_A;
          2'b00:   state_next = IDLE;
          default: state_next = IN_B;
        endcase
      end
      IN_C: begin
        case (beams)
          2'b00: begin
            state_next = IDLE;
            in_evt     = 1'b1;
          end
          2'b11:   state_next = IN_B;
          2'b10:   state_next = IN_A;
          default: state_next = IN_C;
        endcase
      end
      OUT_A: begin
        case (beams)
          2'b11:   state_next = OUT_B;
          2'b10:   state_next = OUT_C;
          2'b00:   state_next = IDLE;
          default: state_next = OUT_A;
        endcase
      end
      OUT_B: begin
        case (beams)
          2'b10:   state_next = OUT_C;
          2'b01:   state_next = OUT_A;
          2'b00:   state_next = IDLE;
          default: state_next = OUT_B;
        endcase
      end
      OUT_C: begin
        case (beams)
          2'b00: begin
            state_next = IDLE;
            out_evt    = 1'b1;
          end
          2'b11:   state_next = OUT_B;
          2'b01:   state_next = OUT_A;
          default: state_next = OUT_C;
        endcase
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    occ_next = occupancy;
    if (in_evt && (occupancy != CAP))
      occ_next = occupancy + 1'b1;
    else if (out_evt && (occupancy != '0))
      occ_next = occupancy - 1'b1;
  end

  // Full/empty flags are derived from the next count so they never lag occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      car_in_pulse  <= 1'b0;
      car_out_pulse <= 1'b0;
      occupancy     <= '0;
      lot_full      <= 1'b0;
      lot_empty     <= 1'b1;
    end else begin
      state         <= state_next;
      car_in_pulse  <= in_evt;
      car_out_pulse <= out_evt;
      occupancy     <= occ_next;
      lot_full      <= (occ_next == CAP);
      lot_empty     <= (occ_next == '0);
    end
  end

  assign sensor_entrance = deb_entrance & ~lot_full;
  assign sensor_exit     = deb_exit;

endmodule

// File: tb/tb_parking_gate_sensor_frontend.sv
// Directed bench for the gate sensor front end: reset, glitch rejection,
// passages, abort/reverse, saturation with entrance gating and reset mid-passage.
module tb_parking_gate_sensor_frontend;
  import parking_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       raw_entrance = 1'b0;
  logic       raw_exit = 1'b0;
  logic       sensor_entrance;
  logic       sensor_exit;
  logic       car_in_pulse;
  logic       car_out_pulse;
  logic [3:0] occupancy;
  logic       lot_full;
  logic       lot_empty;

  int n_compared   = 0;
  int n_mismatched = 0;
  int in_seen      = 0;
  int out_seen     = 0;

  always #5 clk = ~clk;

  parking_gate_sensor_frontend #(
    .DEBOUNCE_CYCLES (4),
    .CAPACITY        (8),
    .CNT_W           (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .raw_entrance    (raw_entrance),
    .raw_exit        (raw_exit),
    .sensor_entrance (sensor_entrance),
    .sensor_exit     (sensor_exit),
    .car_in_pulse    (car_in_pulse),
    .car_out_pulse   (car_out_pulse),
    .occupancy       (occupancy),
    .lot_full        (lot_full),
    .lot_empty       (lot_empty)
  );

  // Pulses are one cycle wide, so sampling on the falling edge counts each once.
  always @(negedge clk) begin
    if (car_in_pulse)  in_seen++;
    if (car_out_pulse) out_seen++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic e, input logic x, input int n);
    raw_entrance = e;
    raw_exit     = x;
    tick(n);
  endtask

  task automatic inbound();
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 10);
  endtask

  task automatic outbound();
    hold(1'b0, 1'b1, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 10);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) begin
      raw_entrance = 1'($urandom_range(0, 1));
      raw_exit     = 1'($urandom_range(0, 1));
      tick(1);
    end
    n_compared++;
    if ({sensor_entrance, sensor_exit, car_in_pulse, car_out_pulse, lot_full, lot_empty, occupancy} !== 10'b0000010000) begin
      n_mismatched++;
      $display("[TB] FAIL reset_outputs: got %b required %b",
               {sensor_entrance, sensor_exit, car_in_pulse, car_out_pulse, lot_full, lot_empty, occupancy}, 10'b0000010000);
    end
    raw_entrance = 1'b0;
    raw_exit     = 1'b0;
    reset        = 1'b0;
    tick(4);
    raw_entrance = 1'b1;
    raw_exit     = 1'b1;
    tick(5);
    n_compared++;
    if ({sensor_entrance, sensor_exit} !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL sensors_early: got %b required 00", {sensor_entrance, sensor_exit});
    end
    tick(1);
    n_compared++;
    if ({sensor_entrance, sensor_exit} !== 2'b11) begin
      n_mismatched++;
      $display("[TB] FAIL sensors_on_time: got %b required 11", {sensor_entrance, sensor_exit});
    end
    tick(1);
    n_compared++;
    if (dut.state !== IDLE) begin
      n_mismatched++;
      $display("[TB] FAIL ambiguous_start_state: got %0d required %0d", dut.state, IDLE);
    end
    hold(1'b0, 1'b0, 10);
    n_compared++;
    if ({sensor_entrance, sensor_exit} !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL sensors_release: got %b required 00", {sensor_entrance, sensor_exit});
    end
  endtask

  task automatic test_glitch();
    logic seen_high;
    logic left_idle;
    seen_high = 1'b0;
    left_idle = 1'b0;
    hold(1'b1, 1'b0, 3);
    raw_entrance = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (sensor_entrance !== 1'b0) seen_high = 1'b1;
      if (dut.state !== IDLE) left_idle = 1'b1;
    end
    n_compared++;
    if (seen_high !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL glitch_sensor: got %b required 0", seen_high);
    end
    n_compared++;
    if (left_idle !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL glitch_state_left_idle: got %b required 0", left_idle);
    end
    raw_entrance = 1'b1;
    tick(5);
    n_compared++;
    if (sensor_entrance !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL pulse_sensor_early: got %b required 0", sensor_entrance);
    end
    tick(1);
    n_compared++;
    if (sensor_entrance !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL pulse_sensor_6cyc: got %b required 1", sensor_entrance);
    end
    tick(1);
    n_compared++;
    if (dut.state !== IN_A) begin
      n_mismatched++;
      $display("[TB] FAIL pulse_state: got %0d required %0d", dut.state, IN_A);
    end
    tick(3);
    hold(1'b0, 1'b0, 10);
  endtask

  task automatic test_inbound();
    int in0;
    int out0;
    in0  = in_seen;
    out0 = out_seen;
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 10);
    raw_exit = 1'b0;
    tick(6);
    n_compared++;
    if ({occupancy, lot_empty} !== {4'd0, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL inbound_before_edge: got occ=%0d empty=%b required occ=0 empty=1", occupancy, lot_empty);
    end
    tick(1);
    n_compared++;
    if ({occupancy, lot_empty, car_in_pulse} !== {4'd1, 1'b0, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL inbound_edge: got occ=%0d empty=%b pulse=%b required occ=1 empty=0 pulse=1",
               occupancy, lot_empty, car_in_pulse);
    end
    tick(3);
    n_compared++;
    if ((in_seen - in0) !== 1 || (out_seen - out0) !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL inbound_pulse_count: got in=%0d out=%0d required in=1 out=0", in_seen - in0, out_seen - out0);
    end
  endtask

  task automatic test_abort_reverse();
    int in0;
    int out0;
    in0  = in_seen;
    out0 = out_seen;
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 10);
    n_compared++;
    if ((in_seen - in0) !== 0 || (out_seen - out0) !== 0 || occupancy !== 4'd1) begin
      n_mismatched++;
      $display("[TB] FAIL abort: got in=%0d out=%0d occ=%0d required in=0 out=0 occ=1",
               in_seen - in0, out_seen - out0, occupancy);
    end
    outbound();
    n_compared++;
    if ((out_seen - out0) !== 1 || occupancy !== 4'd0 || lot_empty !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL outbound: got out=%0d occ=%0d empty=%b required out=1 occ=0 empty=1",
               out_seen - out0, occupancy, lot_empty);
    end
  endtask

  task automatic test_saturation();
    int in0;
    int out0;
    for (int i = 0; i < 8; i++) inbound();
    n_compared++;
    if ({occupancy, lot_full, lot_empty} !== {4'd8, 1'b1, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL fill_to_capacity: got occ=%0d full=%b empty=%b required occ=8 full=1 empty=0",
               occupancy, lot_full, lot_empty);
    end
    in0 = in_seen;
    hold(1'b1, 1'b0, 10);
    n_compared++;
    if (sensor_entrance !== 1'b0 || dut.state !== IN_A) begin
      n_mismatched++;
      $display("[TB] FAIL full_gating: got sensor=%b state=%0d required sensor=0 state=%0d",
               sensor_entrance, dut.state, IN_A);
    end
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 10);
    n_compared++;
    if (sensor_exit !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL exit_ungated: got %b required 1", sensor_exit);
    end
    hold(1'b0, 1'b0, 10);
    n_compared++;
    if ((in_seen - in0) !== 1 || occupancy !== 4'd8) begin
      n_mismatched++;
      $display("[TB] FAIL ninth_car: got in=%0d occ=%0d required in=1 occ=8", in_seen - in0, occupancy);
    end
    outbound();
    hold(1'b1, 1'b0, 10);
    n_compared++;
    if (sensor_entrance !== 1'b1 || lot_full !== 1'b0 || occupancy !== 4'd7) begin
      n_mismatched++;
      $display("[TB] FAIL ungated_below_full: got sensor=%b full=%b occ=%0d required sensor=1 full=0 occ=7",
               sensor_entrance, lot_full, occupancy);
    end
    hold(1'b0, 1'b0, 10);
    for (int i = 0; i < 7; i++) outbound();
    n_compared++;
    if ({occupancy, lot_empty} !== {4'd0, 1'b1}) begin
      n_mismatched++;
      $display("[TB] FAIL drain: got occ=%0d empty=%b required occ=0 empty=1", occupancy, lot_empty);
    end
    out0 = out_seen;
    outbound();
    n_compared++;
    if ((out_seen - out0) !== 1 || occupancy !== 4'd0) begin
      n_mismatched++;
      $display("[TB] FAIL underflow: got out=%0d occ=%0d required out=1 occ=0", out_seen - out0, occupancy);
    end
  endtask

  task automatic test_reset_mid();
    int in0;
    int out0;
    for (int i = 0; i < 3; i++) inbound();
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    n_compared++;
    if (dut.state !== IN_B || occupancy !== 4'd3) begin
      n_mismatched++;
      $display("[TB] FAIL mid_setup: got state=%0d occ=%0d required state=%0d occ=3", dut.state, occupancy, IN_B);
    end
    in0   = in_seen;
    out0  = out_seen;
    reset = 1'b1;
    tick(2);
    n_compared++;
    if (dut.state !== IDLE || occupancy !== 4'd0 || lot_empty !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL mid_reset: got state=%0d occ=%0d empty=%b required state=0 occ=0 empty=1",
               dut.state, occupancy, lot_empty);
    end
    raw_entrance = 1'b0;
    raw_exit     = 1'b1;
    reset        = 1'b0;
    tick(10);
    hold(1'b0, 1'b0, 10);
    n_compared++;
    if ((in_seen - in0) !== 0 || (out_seen - out0) !== 0 || occupancy !== 4'd0) begin
      n_mismatched++;
      $display("[TB] FAIL after_mid_reset: got in=%0d out=%0d occ=%0d required in=0 out=0 occ=0",
               in_seen - in0, out_seen - out0, occupancy);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_inbound();
    test_abort_reverse();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
